// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
//
// Purpose: state encoding, SPI mode constant and the default frame width
// shared by spi_master_peek and its phase counter. No ports.
package spi_pkg;

  // {CPOL, CPHA}; this block only implements mode 0.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Matches the width of the slave-side peek/poke shift register.
  localparam int SPI_DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_e;

  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - reloadable phase counter with terminal-count strobe
//
// Purpose: times the chip-select setup/hold and SCLK half-periods.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   load, load_val   reload the counter with (phase length - 1)
//   tc               high while the count is zero, i.e. in the last cycle
//                    of the current phase
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so an idle counter keeps tc asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_master_peek.sv
// rtl/spi_master_peek.sv - mode-0 full-duplex SPI master, fixed-width frames
//
// Purpose: shifts a WIDTH-bit word out MSB first on spi_mosi while capturing
// spi_miso, then returns the received word with a one-cycle done pulse.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   start, data_in        request and word to send (accepted when busy=0)
//   data_out, busy, done  received word, frame in progress, end-of-frame pulse
//   spi_sel_n, spi_sclk,  chip select (active low), serial clock (idles low),
//   spi_mosi, spi_miso    serial data out / in (miso synchronous to clk)
module spi_master_peek
  import spi_pkg::*;
#(
  parameter int WIDTH    = SPI_DEFAULT_WIDTH,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             spi_sel_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int PH_MAX = spi_max3(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(WIDTH);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] data_out_d;
  logic             busy_d, done_d, sel_n_d, sclk_d, mosi_d;

  logic             ph_load;
  logic [PH_W-1:0]  ph_val;
  logic             ph_tc;

  spi_clk_div #(
    .CNT_W(PH_W)
  ) u_clk_div (
    .clk     (clk),
    .reset   (reset),
    .load    (ph_load),
    .load_val(ph_val),
    .tc      (ph_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sel_n <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      data_out  <= data_out_d;
      busy      <= busy_d;
      done      <= done_d;
      spi_sel_n <= sel_n_d;
      spi_sclk  <= sclk_d;
      spi_mosi  <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    data_out_d = data_out;
    busy_d     = busy;
    done_d     = 1'b0;
    sel_n_d    = spi_sel_n;
    sclk_d     = spi_sclk;
    mosi_d     = spi_mosi;
    ph_load    = 1'b0;
    ph_val     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = data_in;
          bit_d   = '0;
          sel_n_d = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = data_in[WIDTH-1];
          ph_load = 1'b1;
          ph_val  = PH_W'(CS_SETUP - 1);
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (ph_tc) begin
          sclk_d  = 1'b1;
          ph_load = 1'b1;
          ph_val  = PH_W'(CLK_DIV - 1);
          state_d = HIGH;
        end
      end

      // The falling SCLK edge is where the master samples miso and moves
      // mosi on; the slave sampled mosi on the preceding rise.
      HIGH: begin
        if (ph_tc) begin
          sclk_d = 1'b0;
          rx_d   = {rx_q[WIDTH-2:0], spi_miso};
          bit_d  = bit_q + BIT_W'(1);
          if (bit_q != LAST_BIT) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[WIDTH-2];
          end
          ph_load = 1'b1;
          ph_val  = PH_W'(CLK_DIV - 1);
          state_d = LOW;
        end
      end

      LOW: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          if (bit_q == ALL_BITS) begin
            ph_val  = PH_W'(CS_HOLD - 1);
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            ph_val  = PH_W'(CLK_DIV - 1);
            state_d = HIGH;
          end
        end
      end

      HOLD: begin
        if (ph_tc) begin
          sel_n_d    = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          data_out_d = rx_q;
          mosi_d     = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_peek.sv
// tb/tb_spi_master_peek.sv - self-checking bench for spi_master_peek
module tb_spi_master_peek;

  localparam int W8 = 8,  D8 = 2, S8 = 1, H8 = 1;
  localparam int L8 = S8 + 2 * D8 * W8 + H8;
  localparam int W32 = 32, D32 = 4, S32 = 2, H32 = 2;
  localparam int L32 = S32 + 2 * D32 * W32 + H32;
  localparam logic [7:0] SLAVE_WORD = 8'h3C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  data8 = 8'h00;
  logic [7:0]  dout8;
  logic        busy8, done8, sel8, sclk8, mosi8, miso8;
  logic        loop8 = 1'b1;

  logic        start32 = 1'b0;
  logic [31:0] data32 = 32'h0;
  logic [31:0] dout32;
  logic        busy32, done32, sel32, sclk32, mosi32, miso32;

  int checks = 0;
  int errors = 0;

  spi_master_peek #(.WIDTH(W8), .CLK_DIV(D8), .CS_SETUP(S8), .CS_HOLD(H8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data_in(data8), .data_out(dout8),
    .busy(busy8), .done(done8), .spi_sel_n(sel8), .spi_sclk(sclk8),
    .spi_mosi(mosi8), .spi_miso(miso8)
  );

  spi_master_peek dut32 (
    .clk(clk), .reset(reset), .start(start32), .data_in(data32), .data_out(dout32),
    .busy(busy32), .done(done32), .spi_sel_n(sel32), .spi_sclk(sclk32),
    .spi_mosi(mosi32), .spi_miso(miso32)
  );

  // Slave: samples mosi on SCLK rise, presents the next bit after the fall.
  logic [7:0] slave_sh = SLAVE_WORD;
  logic [7:0] slave_rx = 8'h00;
  always @(negedge sclk8 or posedge sel8) begin
    if (sel8 !== 1'b0) slave_sh <= SLAVE_WORD;
    else               slave_sh <= {slave_sh[6:0], 1'b0};
  end
  always @(posedge sclk8) slave_rx <= {slave_rx[6:0], mosi8};

  assign miso8  = loop8 ? mosi8 : slave_sh[7];
  assign miso32 = mosi32;

  int         rises8 = 0;
  logic [7:0] cap8 = 8'h00;
  always @(posedge sclk8) begin
    rises8 <= rises8 + 1;
    cap8   <= {cap8[6:0], mosi8};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {sel_n, sclk, mosi, busy, done, data_out} t cycles after the
  // accepting edge, from the frame timing rules alone.
  function automatic logic [36:0] model_out(input bit act, input int t,
      input int w, input int d, input int s, input int h,
      input logic [31:0] tx, input logic [31:0] dout);
    int l, idx;
    logic sel_n, sclk, mosi, busy, dn;
    l = s + 2 * d * w + h;
    sel_n = 1'b1; sclk = 1'b0; mosi = 1'b0; busy = 1'b0; dn = 1'b0;
    if (act && t < l) begin
      sel_n = 1'b0;
      busy  = 1'b1;
      if (t >= s && t < s + 2 * d * w) sclk = (((t - s) / d) % 2) == 0;
      if (t < s + d) idx = 0;
      else           idx = (t - s - d) / (2 * d) + 1;
      if (idx > w - 1) idx = w - 1;
      mosi = tx[w - 1 - idx];
    end else if (act && t == l) begin
      dn = 1'b1;
    end
    return {sel_n, sclk, mosi, busy, dn, dout};
  endfunction

  bit          m8_act = 0, m32_act = 0;
  int          m8_t = 0, m32_t = 0;
  logic [31:0] m8_tx = 0, m8_rx = 0, m8_dout = 0;
  logic [31:0] m32_tx = 0, m32_rx = 0, m32_dout = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m8_act = 0; m8_dout = 0; m32_act = 0; m32_dout = 0;
      end else begin
        if (m8_act && m8_t < L8) m8_t++;
        else if (start8) begin
          m8_act = 1; m8_t = 0; m8_tx = {24'h0, data8};
          m8_rx = loop8 ? {24'h0, data8} : {24'h0, SLAVE_WORD};
        end else m8_act = 0;
        if (m8_act && m8_t == L8) m8_dout = m8_rx;

        if (m32_act && m32_t < L32) m32_t++;
        else if (start32) begin
          m32_act = 1; m32_t = 0; m32_tx = data32; m32_rx = data32;
        end else m32_act = 0;
        if (m32_act && m32_t == L32) m32_dout = m32_rx;
      end
      @(negedge clk);
      if (reset) begin
        m8_act = 0; m8_dout = 0; m32_act = 0; m32_dout = 0;
      end
      chk("cyc8", {27'h0, sel8, sclk8, mosi8, busy8, done8, 24'h0, dout8},
          {27'h0, model_out(m8_act, m8_t, W8, D8, S8, H8, m8_tx, m8_dout)});
      chk("cyc32", {27'h0, sel32, sclk32, mosi32, busy32, done32, dout32},
          {27'h0, model_out(m32_act, m32_t, W32, D32, S32, H32, m32_tx, m32_dout)});
    end
  end

  task automatic start_frame8(input logic [7:0] word);
    @(posedge clk); #1;
    data8 = word; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0, hi_bad, lo_bad, rises, run;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    chk("rst8", {sel8, sclk8, mosi8, busy8, done8, dout8}, {5'b10000, 8'h00});
    chk("rst32", {sel32, sclk32, mosi32, busy32, done32, dout32}, {5'b10000, 32'h0});
    reset = 1'b0;

    // Loopback 0xA5
    loop8 = 1'b1;
    r0 = rises8;
    start_frame8(8'hA5);
    wait_done8(n);
    chk("lat8", n, 34);
    chk("rises8", rises8 - r0, 8);
    chk("mosi_bits8", cap8, 8'hA5);
    chk("dout_a5", dout8, 8'hA5);

    // Slave returns 0x3C while master sends 0xFF
    loop8 = 1'b0;
    start_frame8(8'hFF);
    wait_done8(n);
    chk("dout_slave", dout8, 8'h3C);
    chk("slave_cap", slave_rx, 8'hFF);
    loop8 = 1'b1;

    // start held during a frame, then back-to-back start in the done cycle
    start_frame8(8'h69);
    repeat (4) begin @(posedge clk); #1; end
    start8 = 1'b1; data8 = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    start8 = 1'b0;
    wait_done8(n);
    chk("lat_ignore", n, 27);
    chk("dout_69", dout8, 8'h69);
    chk("gap_sel_hi", sel8, 1'b1);
    start8 = 1'b1; data8 = 8'h5A;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("gap_sel_lo", {sel8, busy8}, 2'b01);
    wait_done8(n);
    chk("lat_b2b", n, 34);
    chk("dout_5a", dout8, 8'h5A);

    // Asynchronous reset at bit 4
    r0 = rises8;
    start_frame8(8'hC3);
    n = 0;
    while (rises8 - r0 < 4 && n < 200) begin @(posedge clk); #1; n++; end
    chk("pre_rst_busy", busy8, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst8", {sel8, sclk8, mosi8, busy8, done8, dout8}, {5'b10000, 8'h00});
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    start_frame8(8'h96);
    wait_done8(n);
    chk("lat_after_rst", n, 34);
    chk("dout_96", dout8, 8'h96);

    // Default parameters, loopback 0x8000_0001
    @(posedge clk); #1;
    data32 = 32'h8000_0001; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    n = 0; hi_bad = 0; lo_bad = 0; rises = 0; run = 0; prev = 1'b0;
    while (done32 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (sclk32 === prev) run++;
      else begin
        if (prev == 1'b1) begin
          if (run != 4) hi_bad++;
        end else if (rises > 0) begin
          if (run != 4) lo_bad++;
        end
        if (sclk32 === 1'b1) rises++;
        run = 1;
        prev = sclk32;
      end
    end
    chk("lat32", n, 260);
    chk("rises32", rises, 32);
    chk("hi_phase32", hi_bad, 0);
    chk("lo_phase32", lo_bad, 0);
    chk("dout32", dout32, 32'h8000_0001);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
